// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   XLEN_D, NREG_D : default data width and register count
//   wr_select()    : picks the highest-index asserted bit of a port-hit vector,
//                    which implements "highest-index write port wins"
package regfile_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;

  // Upper bound on write ports that wr_select() can arbitrate.
  localparam int WP_MAX = 32;

  typedef struct packed {
    logic       hit;
    logic [4:0] port;
  } wsel_t;

  function automatic wsel_t wr_select(input logic [WP_MAX-1:0] hits);
    wsel_t s;
    s = '0;
    for (int unsigned p = 0; p < WP_MAX; p++) begin
      if (hits[p]) begin
        s.hit  = 1'b1;
        s.port = 5'(p);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for RAW/WAW hazard tracking.
//   i_clk, i_rst (async, active-low)
//   i_wr_en / i_wr_addr : writeback ports, each clears pending[addr]
//   i_iss_en / i_iss_addr : reserve a destination, sets pending[addr]
//   i_flush             : clear every pending bit (beats issue and writeback)
//   o_iss_ready         : reservation accepted this cycle (combinational)
//   o_pending           : raw scoreboard state
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_addr,
  input  logic              i_flush,
  output logic              o_iss_ready,
  output logic [NREG-1:0]   o_pending
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_iss_wb;

  always_comb begin
    w_clr    = '0;
    w_iss_wb = 1'b0;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (i_wr_en[p]) begin
        w_clr[i_wr_addr[p*AW +: AW]] = 1'b1;
        if (i_wr_addr[p*AW +: AW] == i_iss_addr) w_iss_wb = 1'b1;
      end
    end

    // A writeback landing on the requested register frees it this cycle.
    o_iss_ready = !i_flush &&
                  ((i_iss_addr == '0) || !r_pending[i_iss_addr] || w_iss_wb);

    w_set = '0;
    if (i_iss_en && o_iss_ready) w_set[i_iss_addr] = 1'b1;

    // Set is OR-ed after the clear so a new producer supersedes the old one.
    if (i_flush) w_pending_nxt = '0;
    else         w_pending_nxt = (r_pending & ~w_clr) | w_set;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with destination scoreboard.
// Register 0 reads as zero, ignores writes and is never pending.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads
// (highest-index matching write port) and forces busy low for those reads.
//   i_clk, i_rst (async, active-low)
//   i_rs_addr / o_rs_data / o_rs_busy : combinational read ports
//   i_wr_en / i_wr_addr / i_wr_data   : synchronous write ports
//   i_iss_en / i_iss_addr / o_iss_ready : destination reservation
//   i_flush : clear scoreboard; o_pending : scoreboard state
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic                i_iss_en,
  input  logic [AW-1:0]       i_iss_addr,
  output logic                o_iss_ready,
  input  logic                i_flush,
  output logic [NREG-1:0]     o_pending
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_we   [NREG];
  logic [XLEN-1:0] w_wd   [NREG];
  logic [NREG-1:0] w_pending;

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_iss_en    (i_iss_en),
    .i_iss_addr  (i_iss_addr),
    .i_flush     (i_flush),
    .o_iss_ready (o_iss_ready),
    .o_pending   (w_pending)
  );

  assign o_pending = w_pending;

  // Per-register write merge: collapse all ports hitting a register into one
  // enable plus the data of the highest-index hitting port.
  always_comb begin : wr_merge
    logic [WP_MAX-1:0] v_hits;
    wsel_t             v_sel;
    for (int unsigned r = 0; r < NREG; r++) begin
      v_hits = '0;
      for (int unsigned p = 0; p < NWR; p++)
        v_hits[p] = i_wr_en[p] && (i_wr_addr[p*AW +: AW] == AW'(r));
      v_sel   = wr_select(v_hits);
      w_we[r] = v_sel.hit && (r != 0);
      w_wd[r] = i_wr_data[v_sel.port*XLEN +: XLEN];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++)
        if (w_we[r]) r_regs[r] <= w_wd[r];
    end
  end

  always_comb begin : rd_mux
    logic [AW-1:0]   v_a;
    logic [XLEN-1:0] v_d;
    logic            v_b;
`ifdef REGFILE_BYPASS_EN
    logic [WP_MAX-1:0] v_hits;
    wsel_t             v_sel;
`endif
    o_rs_data = '0;
    o_rs_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      v_a = i_rs_addr[k*AW +: AW];
      v_d = (v_a == '0) ? '0 : r_regs[v_a];
      v_b = w_pending[v_a];
`ifdef REGFILE_BYPASS_EN
      v_hits = '0;
      for (int unsigned p = 0; p < NWR; p++)
        v_hits[p] = i_wr_en[p] && (i_wr_addr[p*AW +: AW] == v_a);
      v_sel = wr_select(v_hits);
      if (v_sel.hit && (v_a != '0)) begin
        v_d = i_wr_data[v_sel.port*XLEN +: XLEN];
        v_b = 1'b0;
      end
`endif
      o_rs_data[k*XLEN +: XLEN] = v_d;
      o_rs_busy[k]              = v_b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                i_clk;
  logic                i_rst;
  logic [NRD*AW-1:0]   i_rs_addr;
  logic [NRD*XLEN-1:0] o_rs_data;
  logic [NRD-1:0]      o_rs_busy;
  logic [NWR-1:0]      i_wr_en;
  logic [NWR*AW-1:0]   i_wr_addr;
  logic [NWR*XLEN-1:0] i_wr_data;
  logic                i_iss_en;
  logic [AW-1:0]       i_iss_addr;
  logic                o_iss_ready;
  logic                i_flush;
  logic [NREG-1:0]     o_pending;

  // Bench-side stimulus variables, packed onto the DUT buses.
  logic [AW-1:0]   ra   [NRD];
  logic            wen  [NWR];
  logic [AW-1:0]   wa   [NWR];
  logic [XLEN-1:0] wd   [NWR];

  assign i_rs_addr = {ra[1], ra[0]};
  assign i_wr_en   = {wen[1], wen[0]};
  assign i_wr_addr = {wa[1], wa[0]};
  assign i_wr_data = {wd[1], wd[0]};

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rs_addr   (i_rs_addr),
    .o_rs_data   (o_rs_data),
    .o_rs_busy   (o_rs_busy),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_iss_en    (i_iss_en),
    .i_iss_addr  (i_iss_addr),
    .o_iss_ready (o_iss_ready),
    .i_flush     (i_flush),
    .o_pending   (o_pending)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers and pending set.
  logic [XLEN-1:0] mregs [NREG];
  logic [NREG-1:0] mpend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NWR; p++) begin wen[p] = 1'b0; wa[p] = '0; wd[p] = '0; end
    ra[0] = '0; ra[1] = '0;
    i_iss_en = 1'b0; i_iss_addr = '0; i_flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) mregs[r] = '0;
    mpend = '0;
  endtask

  function automatic logic m_ready();
    logic wb_hit;
    wb_hit = 1'b0;
    for (int p = 0; p < NWR; p++) if (wen[p] && wa[p] == i_iss_addr) wb_hit = 1'b1;
    return !i_flush && (i_iss_addr == 0 || !mpend[i_iss_addr] || wb_hit);
  endfunction

  task automatic m_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
    d = (a == 0) ? '0 : mregs[a];
    b = mpend[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NWR; p++)
      if (wen[p] && wa[p] == a && a != 0) begin d = wd[p]; b = 1'b0; end
`endif
  endtask

  // Apply the architectural effect of the current inputs at the coming edge.
  task automatic m_commit();
    logic rdy;
    rdy = m_ready();
    for (int p = 0; p < NWR; p++) if (wen[p] && wa[p] != 0) mregs[wa[p]] = wd[p];
    if (i_flush) mpend = '0;
    else begin
      for (int p = 0; p < NWR; p++) if (wen[p]) mpend[wa[p]] = 1'b0;
      if (i_iss_en && rdy) mpend[i_iss_addr] = 1'b1;
    end
    mpend[0] = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [XLEN-1:0] d;
    logic            b;
    for (int k = 0; k < NRD; k++) begin
      m_read(ra[k], d, b);
      check($sformatf("%s rd%0d", tag, k), o_rs_data[k*XLEN +: XLEN], d);
      check($sformatf("%s busy%0d", tag, k), {31'b0, o_rs_busy[k]}, {31'b0, b});
    end
    check({tag, " ready"}, {31'b0, o_iss_ready}, {31'b0, m_ready()});
    check({tag, " pending"}, o_pending, mpend);
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0; logic [31:0] wd0;
    logic [4:0]  wa1; logic [31:0] wd1;
    logic        ie;  logic [4:0]  ia;  logic fl;
    logic [4:0]  ra0; logic [4:0]  ra1;
    logic [31:0] e_d0; logic [31:0] e_d1;
    logic [1:0]  e_busy; logic e_rdy; logic [31:0] e_pend;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [31:0] exp_d;
    logic        exp_b;

    // Expectations are for the cycle's combinational outputs, before its edge.
    vt[0] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 2'b00, 1, 32'h0};
    vt[1] = '{2'b11, 3, 32'hDEADBEEF, 0, 1, 0, 0, 0, 5, 0, 0, 0, 2'b00, 1, 32'h0};
    vt[2] = '{2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 0, 3, 0, 32'hDEADBEEF, 0, 2'b00, 1, 32'h0};
    vt[3] = '{2'b00, 0, 0, 0, 0, 1, 4, 0, 7, 4, 32'h22, 0, 2'b00, 1, 32'h0};
    vt[4] = '{2'b00, 0, 0, 0, 0, 1, 4, 0, 4, 3, 0, 32'hDEADBEEF, 2'b01, 0, 32'h10};
    vt[5] = '{2'b10, 0, 0, 4, 32'h44, 1, 4, 0, 7, 3, 32'h22, 32'hDEADBEEF, 2'b00, 1, 32'h10};
    vt[6] = '{2'b00, 0, 0, 0, 0, 1, 2, 0, 4, 4, 32'h44, 32'h44, 2'b11, 1, 32'h10};
    vt[7] = '{2'b00, 0, 0, 0, 0, 1, 9, 0, 2, 9, 0, 0, 2'b01, 1, 32'h14};
    vt[8] = '{2'b00, 0, 0, 0, 0, 1, 5, 1, 2, 9, 0, 0, 2'b11, 0, 32'h214};
    vt[9] = '{2'b00, 0, 0, 0, 0, 0, 2, 0, 2, 9, 0, 0, 2'b00, 1, 32'h0};

    idle_inputs();
    model_reset();
    i_rst = 1'b1;
    #1 i_rst = 1'b0;
    #2;
    check("reset rd0", o_rs_data[31:0], 32'h0);
    check("reset busy", {30'b0, o_rs_busy}, 32'h0);
    check("reset pending", o_pending, 32'h0);
    check("reset ready", {31'b0, o_iss_ready}, 32'h1);
    i_flush = 1'b1;
    #1;
    check("reset flush ready", {31'b0, o_iss_ready}, 32'h0);
    i_flush = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      next_cycle();
      wen[0] = vt[i].we[0]; wa[0] = vt[i].wa0; wd[0] = vt[i].wd0;
      wen[1] = vt[i].we[1]; wa[1] = vt[i].wa1; wd[1] = vt[i].wd1;
      i_iss_en = vt[i].ie; i_iss_addr = vt[i].ia; i_flush = vt[i].fl;
      ra[0] = vt[i].ra0; ra[1] = vt[i].ra1;
      #2;
      check($sformatf("vec%0d rd0", i), o_rs_data[31:0], vt[i].e_d0);
      check($sformatf("vec%0d rd1", i), o_rs_data[63:32], vt[i].e_d1);
      check($sformatf("vec%0d busy", i), {30'b0, o_rs_busy}, {30'b0, vt[i].e_busy});
      check($sformatf("vec%0d ready", i), {31'b0, o_iss_ready}, {31'b0, vt[i].e_rdy});
      check($sformatf("vec%0d pending", i), o_pending, vt[i].e_pend);
      m_commit();
    end

    // Same-cycle write/read of a pending register (bypass behaviour).
    next_cycle();
    idle_inputs();
    i_iss_en = 1'b1; i_iss_addr = 6; ra[0] = 6; ra[1] = 6;
    #2;
    check("byp pre rd", o_rs_data[31:0], 32'h0);
    m_commit();
    next_cycle();
    idle_inputs();
    wen[0] = 1'b1; wa[0] = 6; wd[0] = 32'hCAFE; ra[0] = 6; ra[1] = 6;
    #2;
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'hCAFE; exp_b = 1'b0;
`else
    exp_d = 32'h0;    exp_b = 1'b1;
`endif
    check("byp same rd0", o_rs_data[31:0], exp_d);
    check("byp same rd1", o_rs_data[63:32], exp_d);
    check("byp same busy", {30'b0, o_rs_busy}, {30'b0, exp_b, exp_b});
    m_commit();
    next_cycle();
    idle_inputs();
    ra[0] = 6;
    #2;
    check("byp after rd", o_rs_data[31:0], 32'hCAFE);
    check("byp after busy", {31'b0, o_rs_busy[0]}, 32'h0);
    m_commit();

    // Asynchronous reset in the middle of a write + reservation.
    next_cycle();
    idle_inputs();
    wen[0] = 1'b1; wa[0] = 10; wd[0] = 32'h5; i_iss_en = 1'b1; i_iss_addr = 10;
    ra[0] = 3; ra[1] = 6;
    #2;
    i_rst = 1'b0;
    #1;
    check("midrst rd0", o_rs_data[31:0], 32'h0);
    check("midrst pending", o_pending, 32'h0);
    check("midrst ready", {31'b0, o_iss_ready}, 32'h1);
    @(posedge i_clk);
    @(negedge i_clk);
    idle_inputs();
    i_rst = 1'b1;
    model_reset();
    ra[0] = 10;
    #1;
    check("midrst x10", o_rs_data[31:0], 32'h0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      for (int p = 0; p < NWR; p++) begin
        wen[p] = ($urandom_range(0, 2) == 0);
        wa[p]  = AW'($urandom_range(0, 7));
        wd[p]  = $urandom;
      end
      i_iss_en   = $urandom_range(0, 1) == 1;
      i_iss_addr = AW'($urandom_range(0, 7));
      i_flush    = ($urandom_range(0, 15) == 0);
      ra[0] = AW'($urandom_range(0, 7));
      ra[1] = AW'($urandom_range(0, 31));
      #2;
      check_model($sformatf("rnd%0d", c));
      m_commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
